// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 multiply/divide unit that feeds the MIPS
// HI/LO registers. It handles MULT, MULTU, DIV and DIVU, doing one shift-add
// or restoring-divide step per clock, followed by one sign-fix cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Ld,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Architectural state.
  state_t             state_q;
  logic [1:0]         op_q;
  logic               signA_q;
  logic               signB_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   aRaw_q;
  logic [2*WIDTH:0]   acc_q;
  logic [CW-1:0]      count_q;
  logic               busy_q;
  logic               ld_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               divZero_q;

  // Next-state values computed combinationally.
  logic               startSigned;
  logic               aNeg;
  logic               bNeg;
  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic               isDiv;
  logic               isSigned;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH:0]   mulAcc_d;
  logic [WIDTH:0]     divShift;
  logic [WIDTH-1:0]   remNew;
  logic [WIDTH-1:0]   quotNew;
  logic [2*WIDTH:0]   divAcc_d;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;
  logic               divByZero;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;

  // Operand conditioning at Start: signed ops work on magnitudes, with the
  // signs kept aside for the FIX cycle. The most-negative value maps to
  // 2^(WIDTH-1) when viewed as unsigned, which is exactly what we want.
  always_comb begin
    startSigned = ~Op[0];
    aNeg        = startSigned & A[WIDTH-1];
    bNeg        = startSigned & B[WIDTH-1];
    aMag        = aNeg ? (~A + 1'b1) : A;
    bMag        = bNeg ? (~B + 1'b1) : B;
  end

  // One iteration of each algorithm plus the final sign correction. The
  // accumulator holds {carry, hi, multiplier} for multiply and
  // {unused, remainder, quotient} for divide.
  always_comb begin
    isDiv    = op_q[1];
    isSigned = ~op_q[0];

    mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    mulAcc_d = acc_q[0] ? {1'b0, mulSum, acc_q[WIDTH-1:1]}
                        : {1'b0, acc_q[2*WIDTH:1]};

    divShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    quotNew  = {acc_q[WIDTH-2:0], 1'b0};
    remNew   = divShift[WIDTH-1:0];
    if (divShift >= {1'b0, opnd_q}) begin
      remNew     = divShift[WIDTH-1:0] - opnd_q;
      quotNew[0] = 1'b1;
    end
    divAcc_d = {1'b0, remNew, quotNew};

    product = acc_q[2*WIDTH-1:0];
    prodFix = (isSigned && (signA_q ^ signB_q)) ? (~product + 1'b1) : product;
    quotFix = (isSigned && (signA_q ^ signB_q)) ? (~acc_q[WIDTH-1:0] + 1'b1)
                                                 : acc_q[WIDTH-1:0];
    remFix  = (isSigned && signA_q) ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                                    : acc_q[2*WIDTH-1:WIDTH];

    divByZero = isDiv && (opnd_q == '0);

    hi_d = prodFix[2*WIDTH-1:WIDTH];
    lo_d = prodFix[WIDTH-1:0];
    if (divByZero) begin
      hi_d = aRaw_q;
      lo_d = '1;
    end else if (isDiv) begin
      hi_d = remFix;
      lo_d = quotFix;
    end
  end

  // Control FSM and all datapath registers; Clr overrides everything,
  // including a pending FIX, so an aborted operation never pulses Ld.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q   <= IDLE;
      op_q      <= '0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      opnd_q    <= '0;
      aRaw_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      ld_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      divZero_q <= 1'b0;
    end else begin
      ld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            op_q      <= Op;
            signA_q   <= aNeg;
            signB_q   <= bNeg;
            aRaw_q    <= A;
            count_q   <= '0;
            busy_q    <= 1'b1;
            divZero_q <= 1'b0;
            state_q   <= RUN;
            if (Op[1]) begin
              opnd_q <= bMag;
              acc_q  <= {1'b0, {WIDTH{1'b0}}, aMag};
            end else begin
              opnd_q <= aMag;
              acc_q  <= {1'b0, {WIDTH{1'b0}}, bMag};
            end
          end
        end
        RUN: begin
          acc_q   <= isDiv ? divAcc_d : mulAcc_d;
          count_q <= count_q + 1'b1;
          if (count_q == LAST_COUNT) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q      <= hi_d;
          lo_q      <= lo_d;
          divZero_q <= divByZero;
          ld_q      <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy    = busy_q;
  assign Ld      = ld_q;
  assign HI_out  = hi_q;
  assign LO_out  = lo_q;
  assign DivZero = divZero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed tests for the iterative multiply/divide unit.
module tb_mult_div_unit;

  logic        Clk;
  logic        Clr;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Ld;
  logic [31:0] HI_out;
  logic [31:0] LO_out;
  logic        DivZero;

  int checks;
  int failures;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk(Clk),
    .Clr(Clr),
    .Start(Start),
    .Op(Op),
    .A(A),
    .B(B),
    .Busy(Busy),
    .Ld(Ld),
    .HI_out(HI_out),
    .LO_out(LO_out),
    .DivZero(DivZero)
  );

  // Free-running 10-unit clock.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Raises Start for one edge (t0) and returns 1 unit after that edge.
  task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Op    = op;
    A     = a;
    B     = b;
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  // Waits up to 40 cycles for Ld; lat is the cycle count after t0, or -1.
  task automatic waitLd(output int lat);
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge Clk); #1;
      if (Ld === 1'b1) lat = c;
    end
  endtask

  task automatic checkLat(input string name, input int got);
    checks++;
    if (got !== 33) begin
      failures++;
      $display("[TB] FAIL %s latency got=%0d exp=33", name, got);
    end
  endtask

  task automatic checkWord(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic test_reset();
    Clr = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Clr = 1'b0;
    checkBit("reset_busy", Busy, 1'b0);
    checkBit("reset_ld", Ld, 1'b0);
    checkBit("reset_divzero", DivZero, 1'b0);
    checkWord("reset_hi", HI_out, 32'h0);
    checkWord("reset_lo", LO_out, 32'h0);
  endtask

  task automatic test_multu_max();
    int lat;
    int busyBad;
    startOp(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    lat = -1;
    busyBad = 0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge Clk); #1;
      if (Ld === 1'b1) lat = c;
      else if (Busy !== 1'b1) busyBad++;
    end
    checkLat("multu_max", lat);
    checks++;
    if (busyBad != 0) begin
      failures++;
      $display("[TB] FAIL multu_busy_window low_cycles=%0d exp=0", busyBad);
    end
    checkBit("multu_busy_in_ld", Busy, 1'b0);
    checkWord("multu_max_hi", HI_out, 32'hFFFFFFFE);
    checkWord("multu_max_lo", LO_out, 32'h00000001);
    @(posedge Clk); #1;
    checkBit("multu_ld_one_cycle", Ld, 1'b0);
    checkWord("multu_hold_lo", LO_out, 32'h00000001);
  endtask

  task automatic test_mult_signed();
    int lat;
    startOp(OP_MULT, 32'hFFFFFFFD, 32'd7);
    waitLd(lat);
    checkLat("mult_neg", lat);
    checkWord("mult_neg_hi", HI_out, 32'hFFFFFFFF);
    checkWord("mult_neg_lo", LO_out, 32'hFFFFFFEB);
  endtask

  task automatic test_div_signed();
    int lat;
    startOp(OP_DIV, 32'hFFFFFFF9, 32'd2);
    waitLd(lat);
    checkLat("div_neg_dividend", lat);
    checkWord("div_m7_2_lo", LO_out, 32'hFFFFFFFD);
    checkWord("div_m7_2_hi", HI_out, 32'hFFFFFFFF);
    checkBit("div_m7_2_divzero", DivZero, 1'b0);
    // Positive dividend, negative divisor: remainder stays positive.
    startOp(OP_DIV, 32'd7, 32'hFFFFFFFE);
    waitLd(lat);
    checkWord("div_7_m2_lo", LO_out, 32'hFFFFFFFD);
    checkWord("div_7_m2_hi", HI_out, 32'h00000001);
  endtask

  task automatic test_divu();
    int lat;
    startOp(OP_DIVU, 32'd100, 32'd7);
    waitLd(lat);
    checkLat("divu", lat);
    checkWord("divu_lo", LO_out, 32'h0000000E);
    checkWord("divu_hi", HI_out, 32'h00000002);
  endtask

  task automatic test_div_zero();
    int lat;
    startOp(OP_DIVU, 32'h00001234, 32'h0);
    waitLd(lat);
    checkLat("divzero", lat);
    checkWord("divzero_hi", HI_out, 32'h00001234);
    checkWord("divzero_lo", LO_out, 32'hFFFFFFFF);
    checkBit("divzero_flag", DivZero, 1'b1);
    // Flag is sticky until the next accepted Start.
    repeat (3) @(posedge Clk);
    #1;
    checkBit("divzero_sticky", DivZero, 1'b1);
    startOp(OP_DIVU, 32'd100, 32'd7);
    checkBit("divzero_cleared", DivZero, 1'b0);
    waitLd(lat);
    checkWord("divzero_next_lo", LO_out, 32'h0000000E);
  endtask

  task automatic test_overflow();
    int lat;
    startOp(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    waitLd(lat);
    checkWord("ovf_lo", LO_out, 32'h80000000);
    checkWord("ovf_hi", HI_out, 32'h00000000);
    checkBit("ovf_divzero", DivZero, 1'b0);
  endtask

  task automatic test_start_ignored();
    int lat;
    startOp(OP_MULTU, 32'd5, 32'd6);
    lat = -1;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(posedge Clk); #1;
      if (Ld === 1'b1) lat = c;
      if (c == 4) begin
        Op    = OP_DIVU;
        A     = 32'd99;
        B     = 32'd3;
        Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
    end
    checkLat("start_ignored", lat);
    checkWord("start_ignored_hi", HI_out, 32'h0);
    checkWord("start_ignored_lo", LO_out, 32'd30);
  endtask

  task automatic test_clr_abort();
    int ldSeen;
    startOp(OP_MULTU, 32'd5, 32'd6);
    ldSeen = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge Clk); #1;
      if (Ld === 1'b1) ldSeen++;
      Clr = (c == 9) ? 1'b1 : 1'b0;
    end
    checks++;
    if (ldSeen != 0) begin
      failures++;
      $display("[TB] FAIL clr_abort_ld pulses=%0d exp=0", ldSeen);
    end
    checkBit("clr_abort_busy", Busy, 1'b0);
    checkWord("clr_abort_hi", HI_out, 32'h0);
    checkWord("clr_abort_lo", LO_out, 32'h0);
  endtask

  task automatic test_back_to_back();
    int lat;
    startOp(OP_MULTU, 32'd3, 32'd4);
    waitLd(lat);
    checkLat("b2b_first", lat);
    checkWord("b2b_first_lo", LO_out, 32'd12);
    // Still inside the Ld cycle: request the next op for the closing edge.
    startOp(OP_MULTU, 32'd7, 32'd8);
    checkBit("b2b_accepted_busy", Busy, 1'b1);
    waitLd(lat);
    checkLat("b2b_second", lat);
    checkWord("b2b_second_lo", LO_out, 32'd56);
    checkWord("b2b_second_hi", HI_out, 32'd0);
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    checks   = 0;
    failures = 0;
    Clr      = 1'b0;
    Start    = 1'b0;
    Op       = 2'b00;
    A        = 32'h0;
    B        = 32'h0;
    @(posedge Clk); #1;
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_div_signed();
    test_divu();
    test_div_zero();
    test_overflow();
    test_start_ignored();
    test_clr_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
